// File: rtl/ddr_burst_arbiter_if.sv
// Bundle of requester-side and controller-side signals of the DDR burst
// arbiter. The arbiter uses the master view; the environment (requesters and
// ddr_controller model) uses the slave view.
interface ddr_burst_arbiter_if #(
   parameter int DDR_ADDR_WIDTH = 28,
   parameter int LEN_WIDTH      = 10,
   parameter int NPORT          = 3
);
   logic                      init_calib_complete;
   logic [NPORT-1:0]          req;
   logic [DDR_ADDR_WIDTH-1:0] addr_p0, addr_p1, addr_p2;
   logic [LEN_WIDTH-1:0]      len_p0, len_p1, len_p2;
   logic [NPORT-1:0]          grant;
   logic [NPORT-1:0]          done;
   logic [NPORT-1:0]          beat;
   logic                      rd_burst_req, wr_burst_req;
   logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr, wr_burst_addr;
   logic [LEN_WIDTH-1:0]      rd_burst_len, wr_burst_len;
   logic                      rd_burst_data_valid, wr_burst_data_req;
   logic                      rd_burst_finish, wr_burst_finish;
   logic                      busy;
   logic                      len_err;

   modport master (
      input  init_calib_complete, req,
      input  addr_p0, addr_p1, addr_p2, len_p0, len_p1, len_p2,
      input  rd_burst_data_valid, wr_burst_data_req,
      input  rd_burst_finish, wr_burst_finish,
      output grant, done, beat,
      output rd_burst_req, wr_burst_req,
      output rd_burst_addr, wr_burst_addr, rd_burst_len, wr_burst_len,
      output busy, len_err
   );

   modport slave (
      output init_calib_complete, req,
      output addr_p0, addr_p1, addr_p2, len_p0, len_p1, len_p2,
      output rd_burst_data_valid, wr_burst_data_req,
      output rd_burst_finish, wr_burst_finish,
      input  grant, done, beat,
      input  rd_burst_req, wr_burst_req,
      input  rd_burst_addr, wr_burst_addr, rd_burst_len, wr_burst_len,
      input  busy, len_err
   );
endinterface

// File: rtl/ddr_burst_arbiter.sv
// Round-robin arbiter sharing the single ddr_controller burst interface
// between instruction fetch (port 0), data read (port 1) and data store
// (port 2). Latches the winner's address/length, holds the burst request
// until finish, steers beat strobes to the granted port and flags bursts
// whose beat count differs from the requested length.
module ddr_burst_arbiter #(
   parameter int DDR_ADDR_WIDTH = 28,
   parameter int LEN_WIDTH      = 10,
   parameter int NPORT          = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ddr_burst_arbiter_if.master  bus
);

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

   localparam logic [1:0]           WR_PORT = 2'd2;
   localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

   state_t                    state;
   logic [1:0]                rr;
   logic [1:0]                port;
   logic [NPORT-1:0]          grant_q;
   logic [NPORT-1:0]          done_q;
   logic                      rd_req_q, wr_req_q;
   logic                      busy_q, len_err_q;
   logic [DDR_ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]      len_q;
   logic [LEN_WIDTH-1:0]      beat_cnt;
   logic                      sat_q;

   logic                      win_valid;
   logic [1:0]                win_port;
   logic [DDR_ADDR_WIDTH-1:0] win_addr;
   logic [LEN_WIDTH-1:0]      win_len;
   logic [1:0]                cand0, cand1, cand2;
   logic                      beat_in;
   logic                      burst_finish;

   function automatic logic [1:0] next_port(input logic [1:0] p);
      return (p == 2'(NPORT - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   function automatic logic [NPORT-1:0] onehot(input logic [1:0] p);
      return {{(NPORT-1){1'b0}}, 1'b1} << p;
   endfunction

   // Round-robin scan order starting at the pointer.
   assign cand0 = rr;
   assign cand1 = next_port(cand0);
   assign cand2 = next_port(cand1);

   // First requester in scan order wins; mux its address and length.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
      win_valid = 1'b1;
      win_port  = cand0;
      win_addr  = bus.addr_p0;
      win_len   = bus.len_p0;
      if (bus.req[cand0])      win_port = cand0;
      else if (bus.req[cand1]) win_port = cand1;
      else if (bus.req[cand2]) win_port = cand2;
      else                     win_valid = 1'b0;
      case (win_port)
         2'd1: begin
            win_addr = bus.addr_p1;
            win_len  = bus.len_p1;
         end
         2'd2: begin
            win_addr = bus.addr_p2;
            win_len  = bus.len_p2;
         end
         default: ;
      endcase
   end

   // Controller strobe and finish of the active direction only; the other direction is ignored.
   always_comb begin
      beat_in      = 1'b0;
      burst_finish = 1'b0;
      case (state)
         RD_BURST: begin
            beat_in      = bus.rd_burst_data_valid;
            burst_finish = bus.rd_burst_finish;
         end
         WR_BURST: begin
            beat_in      = bus.wr_burst_data_req;
            burst_finish = bus.wr_burst_finish;
         end
         default: ;
      endcase
   end

   assign bus.beat          = grant_q & {NPORT{beat_in}};
   assign bus.grant         = grant_q;
   assign bus.done          = done_q;
   assign bus.rd_burst_req  = rd_req_q;
   assign bus.wr_burst_req  = wr_req_q;
   assign bus.rd_burst_addr = addr_q;
   assign bus.wr_burst_addr = addr_q;
   assign bus.rd_burst_len  = len_q;
   assign bus.wr_burst_len  = len_q;
   assign bus.busy          = busy_q;
   assign bus.len_err       = len_err_q;

   // Arbitration FSM with registered grant, burst request, done and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the latched address/length are reset as well, so the controller-facing outputs are defined from reset on.
      if (!rst_n) begin
         state     <= IDLE;
         rr        <= 2'd0;
         port      <= 2'd0;
         grant_q   <= '0;
         done_q    <= '0;
         rd_req_q  <= 1'b0;
         wr_req_q  <= 1'b0;
         busy_q    <= 1'b0;
         len_err_q <= 1'b0;
         addr_q    <= '0;
         len_q     <= '0;
         beat_cnt  <= '0;
         sat_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the values before this edge.
         done_q <= '0;
         case (state)
            IDLE: begin
               if (bus.init_calib_complete && win_valid) begin
                  port    <= win_port;
                  addr_q  <= win_addr;
                  len_q   <= win_len;
                  grant_q <= onehot(win_port);
                  busy_q  <= 1'b1;
                  if (win_len == '0) begin
                     state  <= DONE;
                     done_q <= onehot(win_port);
                  end else if (win_port == WR_PORT) begin
                     state    <= WR_BURST;
                     wr_req_q <= 1'b1;
                  end else begin
                     state    <= RD_BURST;
                     rd_req_q <= 1'b1;
                  end
               end
            end
            RD_BURST, WR_BURST: begin
               if (beat_in) begin
                  if (beat_cnt == LEN_MAX) sat_q <= 1'b1;
                  else                     beat_cnt <= beat_cnt + 1'b1;
               end
               if (burst_finish) begin
                  state    <= DONE;
                  rd_req_q <= 1'b0;
                  wr_req_q <= 1'b0;
                  done_q   <= grant_q;
               end
            end
            DONE: begin
               if ((len_q != '0) && (sat_q || (beat_cnt != len_q))) len_err_q <= 1'b1;
               rr       <= next_port(port);
               beat_cnt <= '0;
               sat_q    <= 1'b0;
               grant_q  <= '0;
               busy_q   <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Self-checking bench for ddr_burst_arbiter: plays the requesters and the DDR
// controller, and checks the DUT against a transaction-level model of the
// arbitration order, burst timing and sticky length-error flag.
module tb_ddr_burst_arbiter;

   localparam int AW = 28;
   localparam int LW = 10;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   ddr_burst_arbiter_if #(.DDR_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .NPORT(3)) bus ();

   ddr_burst_arbiter #(.DDR_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .NPORT(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [2:0]  req_v;
   logic [AW-1:0] addrs [3];
   logic [LW-1:0] lens  [3];
   int          rr_m;
   bit          len_err_m;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference arbitration: first requesting port counting up from the pointer, modulo 3.
   function automatic int winner(input logic [2:0] mask, input int start);
      for (int i = 0; i < 3; i++) begin
         if (mask[(start + i) % 3]) return (start + i) % 3;
      end
      return -1;
   endfunction

   task automatic drive_req();
      bus.req     = req_v;
      bus.addr_p0 = addrs[0];
      bus.addr_p1 = addrs[1];
      bus.addr_p2 = addrs[2];
      bus.len_p0  = lens[0];
      bus.len_p1  = lens[1];
      bus.len_p2  = lens[2];
   endtask

   task automatic clear_ctrl();
      bus.rd_burst_data_valid = 1'b0;
      bus.wr_burst_data_req   = 1'b0;
      bus.rd_burst_finish     = 1'b0;
      bus.wr_burst_finish     = 1'b0;
   endtask

   task automatic randomize_ports();
      for (int i = 0; i < 3; i++) begin
         addrs[i] = AW'($urandom);
         lens[i]  = ($urandom_range(0, 9) == 0) ? LW'(0) : LW'($urandom_range(1, 6));
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_grant"},   bus.grant,         3'b000);
      check({tag, "_done"},    bus.done,          3'b000);
      check({tag, "_beat"},    bus.beat,          3'b000);
      check({tag, "_rd_req"},  bus.rd_burst_req,  1'b0);
      check({tag, "_wr_req"},  bus.wr_burst_req,  1'b0);
      check({tag, "_rd_addr"}, bus.rd_burst_addr, '0);
      check({tag, "_wr_addr"}, bus.wr_burst_addr, '0);
      check({tag, "_rd_len"},  bus.rd_burst_len,  '0);
      check({tag, "_wr_len"},  bus.wr_burst_len,  '0);
      check({tag, "_busy"},    bus.busy,          1'b0);
      check({tag, "_len_err"}, bus.len_err,       1'b0);
   endtask

   // Serve one grant. Called at a falling edge in IDLE with requests driven;
   // returns at the falling edge of the following IDLE cycle.
   task automatic serve(input int delta, input bit drop);
      int         p;
      logic [2:0] oh;
      int         nbeats;
      int         given;
      int         cyc;
      bit         fin;
      bit         strobe;
      p = winner(req_v, rr_m);
      if (p < 0) return;
      oh = 3'b001 << p;
      @(negedge clk);
      check("grant", bus.grant, oh);
      check("busy", bus.busy, 1'b1);
      if (lens[p] == '0) begin
         check("zl_done",   bus.done,         oh);
         check("zl_rd_req", bus.rd_burst_req, 1'b0);
         check("zl_wr_req", bus.wr_burst_req, 1'b0);
      end else begin
         check("rd_req", bus.rd_burst_req, p != 2);
         check("wr_req", bus.wr_burst_req, p == 2);
         check("addr", (p == 2) ? bus.wr_burst_addr : bus.rd_burst_addr, addrs[p]);
         check("len",  (p == 2) ? bus.wr_burst_len  : bus.rd_burst_len,  lens[p]);
         nbeats = int'(lens[p]) + delta;
         if (nbeats < 0) nbeats = 0;
         given = 0;
         cyc   = 0;
         fin   = 1'b0;
         while (!fin) begin
            strobe = (given < nbeats) && (cyc > 40 || $urandom_range(0, 3) != 0);
            if (strobe) given++;
            fin = (given >= nbeats) && (cyc > 40 || $urandom_range(0, 2) == 0);
            bus.rd_burst_data_valid = (p != 2) ? strobe : 1'($urandom);
            bus.wr_burst_data_req   = (p == 2) ? strobe : 1'($urandom);
            bus.rd_burst_finish     = (p != 2) ? fin    : 1'($urandom);
            bus.wr_burst_finish     = (p == 2) ? fin    : 1'($urandom);
            bus.init_calib_complete = ($urandom_range(0, 3) != 0);
            #1;
            check("beat", bus.beat, strobe ? oh : 3'b000);
            check("req_held", (p == 2) ? bus.wr_burst_req : bus.rd_burst_req, 1'b1);
            check("grant_held", bus.grant, oh);
            cyc++;
            @(negedge clk);
         end
         if (given != int'(lens[p])) len_err_m = 1'b1;
         check("done",        bus.done,         oh);
         check("done_rd_req", bus.rd_burst_req, 1'b0);
         check("done_wr_req", bus.wr_burst_req, 1'b0);
         check("done_grant",  bus.grant,        oh);
      end
      // DONE cycle: controller strobes here must not reach any port.
      bus.rd_burst_data_valid = 1'($urandom);
      bus.wr_burst_data_req   = 1'($urandom);
      bus.rd_burst_finish     = 1'b0;
      bus.wr_burst_finish     = 1'b0;
      bus.init_calib_complete = 1'b1;
      #1;
      check("done_beat", bus.beat, 3'b000);
      rr_m = (p + 1) % 3;
      if (drop) req_v[p] = 1'b0;
      drive_req();
      @(negedge clk);
      clear_ctrl();
      check("idle_grant",   bus.grant,        3'b000);
      check("idle_done",    bus.done,         3'b000);
      check("idle_busy",    bus.busy,         1'b0);
      check("idle_rd_req",  bus.rd_burst_req, 1'b0);
      check("idle_wr_req",  bus.wr_burst_req, 1'b0);
      check("idle_len_err", bus.len_err,      len_err_m);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int delta;
      rst_n     = 1'b0;
      req_v     = 3'b000;
      rr_m      = 0;
      len_err_m = 1'b0;
      for (int i = 0; i < 3; i++) begin
         addrs[i] = '0;
         lens[i]  = '0;
      end
      bus.init_calib_complete = 1'b0;
      clear_ctrl();
      drive_req();
      #12;
      check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;
      bus.init_calib_complete = 1'b1;

      // Round-robin with all three ports requesting, one-beat bursts.
      req_v = 3'b111;
      randomize_ports();
      for (int i = 0; i < 3; i++) lens[i] = LW'(1);
      drive_req();
      for (int i = 0; i < 4; i++) serve(0, 1'b0);

      // Single read on port 0.
      req_v    = 3'b001;
      addrs[0] = AW'('h100);
      lens[0]  = LW'(4);
      drive_req();
      serve(0, 1'b1);

      // Calibration gate holds off a pending request.
      bus.init_calib_complete = 1'b0;
      req_v   = 3'b010;
      lens[1] = LW'(3);
      drive_req();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("cal_grant", bus.grant, 3'b000);
         check("cal_busy",  bus.busy,  1'b0);
      end
      bus.init_calib_complete = 1'b1;
      serve(0, 1'b1);

      // Port 1 asks for 8 beats but the controller delivers 7.
      req_v   = 3'b010;
      lens[1] = LW'(8);
      drive_req();
      serve(-1, 1'b1);

      // Zero-length store.
      req_v   = 3'b100;
      lens[2] = LW'(0);
      drive_req();
      serve(0, 1'b1);

      // Good burst on port 0 moves the pointer to 1; the flag must stay set.
      req_v   = 3'b001;
      lens[0] = LW'(2);
      drive_req();
      serve(0, 1'b1);

      // Reset in the middle of a read burst.
      req_v   = 3'b011;
      lens[0] = LW'(5);
      lens[1] = LW'(5);
      drive_req();
      @(negedge clk);
      check("rst_pre_grant", bus.grant, 3'b001 << winner(req_v, rr_m));
      bus.rd_burst_data_valid = 1'b1;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("rst_async");
      rr_m      = 0;
      len_err_m = 1'b0;
      @(negedge clk);
      check_reset_values("rst_hold");
      clear_ctrl();
      rst_n = 1'b1;
      serve(0, 1'b1);

      // Randomized traffic.
      for (int n = 0; n < 200; n++) begin
         if (req_v == 3'b000 || $urandom_range(0, 3) == 0) req_v = req_v | 3'($urandom_range(1, 7));
         randomize_ports();
         if ($urandom_range(0, 7) == 0) begin
            bus.init_calib_complete = 1'b0;
            drive_req();
            repeat ($urandom_range(1, 4)) begin
               @(negedge clk);
               check("rnd_cal_grant", bus.grant, 3'b000);
               check("rnd_cal_busy",  bus.busy,  1'b0);
            end
            bus.init_calib_complete = 1'b1;
         end
         drive_req();
         delta = 0;
         if ($urandom_range(0, 7) == 0) delta = ($urandom_range(0, 1) == 0) ? 1 : -1;
         serve(delta, 1'($urandom));
         if ($urandom_range(0, 7) == 0) begin
            req_v = 3'b000;
            drive_req();
            repeat (3) begin
               @(negedge clk);
               check("rnd_idle_grant", bus.grant, 3'b000);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
